// File: rtl/ddr_rd_bw_sched.sv
// ---------------------------------------------------------------------------
// ddr_rd_bw_sched
// Sequencer for a single-burst AXI read master used in DDR bandwidth tests.
// Splits a region (base, total bytes) into INCR bursts of at most
// cfg_burst_beats beats that never cross a 4 KB boundary. Each burst goes to
// the read master over a START/ADDR/LENGTH level handshake. The whole region
// is repeated cfg_loops times.
//
// Optional feature: define DDR_RD_BW_SCHED_TIMEOUT_EN to enable a per-burst
// watchdog (TIMEOUT_CYC cycles in ISSUE/WAIT_DONE). Without the macro
// sts_timeout is constant 0 and the sequencer waits on the master forever.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   cfg_start          rising edge starts a run (ignored while busy)
//   cfg_abort          level; finish the current burst, then stop
//   cfg_base_addr      region base (aligned down to the beat size)
//   cfg_total_bytes    region size in bytes (partial beat ignored)
//   cfg_burst_beats    beats per burst (0 -> 1, clamped to MAX_BEATS)
//   cfg_loops          region repetitions (0 -> 1)
//   rd_start           START level to the read master
//   rd_addr, rd_len    burst address and length in beats
//   rd_idle            idle status from the read master
//   sts_busy/done      run in progress / sticky run complete
//   sts_timeout        sticky watchdog flag
//   sts_cycles         saturating cycle count of the run
//   sts_bursts         completed bursts
//   sts_bytes          completed bytes (wraps)
// ---------------------------------------------------------------------------
module ddr_rd_bw_sched #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned MAX_BEATS   = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_start,
    input  logic        cfg_abort,
    input  logic [31:0] cfg_base_addr,
    input  logic [31:0] cfg_total_bytes,
    input  logic [4:0]  cfg_burst_beats,
    input  logic [15:0] cfg_loops,
    output logic        rd_start,
    output logic [31:0] rd_addr,
    output logic [31:0] rd_len,
    input  logic        rd_idle,
    output logic        sts_busy,
    output logic        sts_done,
    output logic        sts_timeout,
    output logic [31:0] sts_cycles,
    output logic [31:0] sts_bursts,
    output logic [31:0] sts_bytes
);

    localparam int unsigned BPB        = DATA_WIDTH / 8;
    localparam int unsigned LOG_BPB    = $clog2(BPB);
    localparam logic [31:0] ALIGN_MASK = ~32'(BPB - 1);
    localparam logic [31:0] MAX_BEATS_W = 32'(MAX_BEATS);

    // Elaboration-time guard on parameter legality.
    if ((BPB == 0) || (BPB > 128) || ((BPB & (BPB - 1)) != 0) ||
        (MAX_BEATS == 0) || (TIMEOUT_CYC == 0)) begin : g_bad_params
        $error("ddr_rd_bw_sched: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic        start_q;
    logic [31:0] base_q, base_n;
    logic [31:0] total_q, total_n;      // region size in beats
    logic [31:0] beats_q, beats_n;      // effective beats per burst
    logic [15:0] loop_cnt, loop_cnt_n;  // loops still to run, including current
    logic [31:0] cur_addr, cur_addr_n;
    logic [31:0] rem_beats, rem_beats_n;
    logic        rd_start_n;
    logic [31:0] rd_addr_n, rd_len_n;
    logic        busy_n, done_n;
    logic [31:0] cycles_n, bursts_n, bytes_n;

    logic        start_rise_c;
    logic [31:0] beats_req_c;
    logic [31:0] total_beats_c;
    logic [31:0] b4k_c;
    logic [31:0] len_c;
    logic [31:0] step_c;
    logic [31:0] rem_after_c;
    logic [15:0] loop_after_c;

`ifdef DDR_RD_BW_SCHED_TIMEOUT_EN
    logic [31:0] wd_cnt, wd_cnt_n;
    logic        timeout_q, timeout_n;
    assign sts_timeout = timeout_q;
`else
    assign sts_timeout = 1'b0;
`endif

    assign start_rise_c  = cfg_start & ~start_q;
    assign total_beats_c = cfg_total_bytes >> LOG_BPB;
    assign step_c        = rd_len << LOG_BPB;

    // Clamp the requested burst length into 1..MAX_BEATS.
    always_comb begin
        beats_req_c = 32'(cfg_burst_beats);
        if (beats_req_c == 32'd0) begin
            beats_req_c = 32'd1;
        end else if (beats_req_c > MAX_BEATS_W) begin
            beats_req_c = MAX_BEATS_W;
        end
    end

    // Burst length: limited by burst size, 4 KB page room and remaining beats.
    always_comb begin
        b4k_c = (32'd4096 - {20'd0, cur_addr[11:0]}) >> LOG_BPB;
        len_c = beats_q;
        if (b4k_c < len_c) begin
            len_c = b4k_c;
        end
        if (rem_beats < len_c) begin
            len_c = rem_beats;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_n      = state;
        base_n       = base_q;
        total_n      = total_q;
        beats_n      = beats_q;
        loop_cnt_n   = loop_cnt;
        cur_addr_n   = cur_addr;
        rem_beats_n  = rem_beats;
        rd_start_n   = rd_start;
        rd_addr_n    = rd_addr;
        rd_len_n     = rd_len;
        busy_n       = sts_busy;
        done_n       = sts_done;
        cycles_n     = sts_cycles;
        bursts_n     = sts_bursts;
        bytes_n      = sts_bytes;
        rem_after_c  = rem_beats - rd_len;
        loop_after_c = loop_cnt - 16'd1;
`ifdef DDR_RD_BW_SCHED_TIMEOUT_EN
        wd_cnt_n     = 32'd0;
        timeout_n    = timeout_q;
`endif

        // Run-time counter: every cycle spent between IDLE and DONE.
        if ((state != S_IDLE) && (state != S_DONE) && (sts_cycles != 32'hFFFF_FFFF)) begin
            cycles_n = sts_cycles + 32'd1;
        end

        case (state)
            S_IDLE: begin
                if (start_rise_c) begin
                    base_n      = cfg_base_addr & ALIGN_MASK;
                    total_n     = total_beats_c;
                    beats_n     = beats_req_c;
                    loop_cnt_n  = (cfg_loops == 16'd0) ? 16'd1 : cfg_loops;
                    cur_addr_n  = cfg_base_addr & ALIGN_MASK;
                    rem_beats_n = total_beats_c;
                    cycles_n    = 32'd0;
                    bursts_n    = 32'd0;
                    bytes_n     = 32'd0;
                    done_n      = 1'b0;
`ifdef DDR_RD_BW_SCHED_TIMEOUT_EN
                    timeout_n   = 1'b0;
`endif
                    if (total_beats_c == 32'd0) begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        busy_n  = 1'b1;
                        state_n = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rd_addr_n = cur_addr;
                rd_len_n  = len_c;
                state_n   = S_ISSUE;
            end
            S_ISSUE: begin
                // Raise START only once the master is idle; then hold it
                // until the master reports busy.
                if (!rd_start) begin
                    if (rd_idle) begin
                        rd_start_n = 1'b1;
                    end
                end else if (!rd_idle) begin
                    rd_start_n = 1'b0;
                    state_n    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                rd_start_n = 1'b0;
                if (rd_idle) begin
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                bursts_n    = sts_bursts + 32'd1;
                bytes_n     = sts_bytes + step_c;
                cur_addr_n  = cur_addr + step_c;
                rem_beats_n = rem_after_c;
                state_n     = S_CALC;
                if (rem_after_c == 32'd0) begin
                    loop_cnt_n = loop_after_c;
                    if (loop_after_c != 16'd0) begin
                        cur_addr_n  = base_q;
                        rem_beats_n = total_q;
                    end else begin
                        state_n = S_DONE;
                    end
                end
                if (cfg_abort) begin
                    state_n = S_DONE;
                end
                if (state_n == S_DONE) begin
                    busy_n = 1'b0;
                    done_n = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

`ifdef DDR_RD_BW_SCHED_TIMEOUT_EN
        // Per-burst watchdog; abandons the burst without counting it.
        if ((state == S_ISSUE) || (state == S_WAIT_DONE)) begin
            wd_cnt_n = wd_cnt + 32'd1;
            if (wd_cnt >= 32'(TIMEOUT_CYC - 1)) begin
                timeout_n  = 1'b1;
                rd_start_n = 1'b0;
                busy_n     = 1'b0;
                done_n     = 1'b1;
                state_n    = S_DONE;
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            base_q     <= 32'd0;
            total_q    <= 32'd0;
            beats_q    <= 32'd0;
            loop_cnt   <= 16'd0;
            cur_addr   <= 32'd0;
            rem_beats  <= 32'd0;
            rd_start   <= 1'b0;
            rd_addr    <= 32'd0;
            rd_len     <= 32'd0;
            sts_busy   <= 1'b0;
            sts_done   <= 1'b0;
            sts_cycles <= 32'd0;
            sts_bursts <= 32'd0;
            sts_bytes  <= 32'd0;
`ifdef DDR_RD_BW_SCHED_TIMEOUT_EN
            wd_cnt     <= 32'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            start_q    <= cfg_start;
            base_q     <= base_n;
            total_q    <= total_n;
            beats_q    <= beats_n;
            loop_cnt   <= loop_cnt_n;
            cur_addr   <= cur_addr_n;
            rem_beats  <= rem_beats_n;
            rd_start   <= rd_start_n;
            rd_addr    <= rd_addr_n;
            rd_len     <= rd_len_n;
            sts_busy   <= busy_n;
            sts_done   <= done_n;
            sts_cycles <= cycles_n;
            sts_bursts <= bursts_n;
            sts_bytes  <= bytes_n;
`ifdef DDR_RD_BW_SCHED_TIMEOUT_EN
            wd_cnt     <= wd_cnt_n;
            timeout_q  <= timeout_n;
`endif
        end
    end

endmodule

// File: tb/tb_ddr_rd_bw_sched.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_bw_sched
// Directed bench for ddr_rd_bw_sched. A behavioural read master accepts
// bursts and checks each one against a queue of expected bursts computed by
// the bench when a run is started. Run-level status is checked at DONE.
// ---------------------------------------------------------------------------
module tb_ddr_rd_bw_sched;

    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned BPB         = DATA_WIDTH / 8;
    localparam int unsigned MAX_BEATS   = 16;
    localparam int unsigned TIMEOUT_CYC = 100;

    logic        clk;
    logic        rstn;
    logic        cfg_start;
    logic        cfg_abort;
    logic [31:0] cfg_base_addr;
    logic [31:0] cfg_total_bytes;
    logic [4:0]  cfg_burst_beats;
    logic [15:0] cfg_loops;
    logic        rd_start;
    logic [31:0] rd_addr;
    logic [31:0] rd_len;
    logic        rd_idle;
    logic        sts_busy;
    logic        sts_done;
    logic        sts_timeout;
    logic [31:0] sts_cycles;
    logic [31:0] sts_bursts;
    logic [31:0] sts_bytes;

    ddr_rd_bw_sched #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MAX_BEATS   (MAX_BEATS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .cfg_start       (cfg_start),
        .cfg_abort       (cfg_abort),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_total_bytes (cfg_total_bytes),
        .cfg_burst_beats (cfg_burst_beats),
        .cfg_loops       (cfg_loops),
        .rd_start        (rd_start),
        .rd_addr         (rd_addr),
        .rd_len          (rd_len),
        .rd_idle         (rd_idle),
        .sts_busy        (sts_busy),
        .sts_done        (sts_done),
        .sts_timeout     (sts_timeout),
        .sts_cycles      (sts_cycles),
        .sts_bursts      (sts_bursts),
        .sts_bytes       (sts_bytes)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
    } burst_t;

    burst_t exp_q[$];
    burst_t m_exp;
    int     checks = 0;
    int     errors = 0;

    // Read master model state.
    bit     m_idle       = 1'b1;
    bit     m_stuck      = 1'b0;
    bit     m_force_busy = 1'b0;
    int     m_cnt        = 0;
    int     accepts      = 0;

    assign rd_idle = m_idle & ~m_force_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Read master: accepts START when idle, stays busy for len+2 cycles and
    // returns to idle only after START has dropped.
    always @(negedge clk) begin
        if (!rstn) begin
            m_idle = 1'b1;
            m_cnt  = 0;
        end else if (m_idle && !m_force_busy) begin
            if (rd_start) begin
                accepts++;
                checks++;
                assert (exp_q.size() != 0)
                else begin
                    errors++;
                    $error("FAIL burst_unexpected: observed addr 0x%08h len %0d expected no burst",
                           rd_addr, rd_len);
                end
                if (exp_q.size() != 0) begin
                    m_exp = exp_q.pop_front();
                    check32("burst_addr", rd_addr, m_exp.addr);
                    check32("burst_len", rd_len, m_exp.len);
                end
                m_idle = 1'b0;
                m_cnt  = int'(rd_len) + 2;
            end
        end else if (!m_idle) begin
            if (m_cnt > 0) m_cnt--;
            if ((m_cnt == 0) && !rd_start && !m_stuck) m_idle = 1'b1;
        end
    end

    // Reference burst split; bytes counts only the first max_n bursts.
    task automatic push_bursts(input logic [31:0] base, input logic [31:0] total,
                               input logic [4:0] beats, input logic [15:0] loops,
                               input int max_n, output int n, output logic [31:0] bytes);
        longint a;
        longint rem;
        longint room;
        longint len;
        longint bl;
        int     loops_eff;
        burst_t b;
        bl        = (beats == 5'd0) ? 1 : ((beats > 5'd16) ? 16 : longint'(beats));
        loops_eff = (loops == 16'd0) ? 1 : int'(loops);
        n         = 0;
        bytes     = 32'd0;
        for (int l = 0; l < loops_eff; l++) begin
            a   = longint'(base) - (longint'(base) % BPB);
            rem = longint'(total) / BPB;
            while (rem > 0) begin
                room = ((((a >> 12) + 1) << 12) - a) / BPB;
                len  = bl;
                if (room < len) len = room;
                if (rem < len) len = rem;
                b.addr = 32'(a);
                b.len  = 32'(len);
                exp_q.push_back(b);
                if (n < max_n) bytes = bytes + 32'(len * BPB);
                n++;
                a   = (a + len * BPB) % 64'h1_0000_0000;
                rem = rem - len;
            end
        end
    endtask

    // One full run: program, start, optionally disturb, wait for DONE, check.
    task automatic run(input string name, input logic [31:0] base, input logic [31:0] total,
                       input logic [4:0] beats, input logic [15:0] loops,
                       input int abort_at, input bit mess, input int force_cyc);
        int          n;
        int          exp_b;
        int          busy_cnt;
        bit          finished;
        logic [31:0] eb;
        cfg_base_addr   = base;
        cfg_total_bytes = total;
        cfg_burst_beats = beats;
        cfg_loops       = loops;
        accepts         = 0;
        push_bursts(base, total, beats, loops, (abort_at > 0) ? abort_at : 32'h7FFF_FFFF, n, eb);
        exp_b = ((abort_at > 0) && (abort_at < n)) ? abort_at : n;
        if (force_cyc > 0) m_force_busy = 1'b1;
        @(negedge clk);
        cfg_start = 1'b1;
        busy_cnt  = 0;
        finished  = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (i == 0) cfg_start = 1'b0;
            if (mess && (i == 20)) begin
                cfg_start       = 1'b1;
                cfg_base_addr   = 32'hDEAD_BEE0;
                cfg_total_bytes = 32'h0000_0010;
                cfg_burst_beats = 5'd1;
                cfg_loops       = 16'd7;
            end
            if (mess && (i == 22)) cfg_start = 1'b0;
            if ((force_cyc > 0) && (i == force_cyc)) begin
                check32({name, "_start_held"}, 32'(rd_start), 32'd0);
                check32({name, "_busy_held"}, 32'(sts_busy), 32'd1);
                m_force_busy = 1'b0;
            end
            if ((abort_at > 0) && (accepts >= abort_at)) cfg_abort = 1'b1;
            if (sts_busy) busy_cnt++;
            if (sts_done) begin
                finished = 1'b1;
                break;
            end
        end
        cfg_abort = 1'b0;
        check32({name, "_finished"}, 32'(finished), 32'd1);
        check32({name, "_busy"}, 32'(sts_busy), 32'd0);
        check32({name, "_rd_start"}, 32'(rd_start), 32'd0);
        check32({name, "_timeout"}, 32'(sts_timeout), 32'd0);
        check32({name, "_bursts"}, sts_bursts, 32'(exp_b));
        check32({name, "_bytes"}, sts_bytes, eb);
        check32({name, "_cycles"}, sts_cycles, 32'(busy_cnt));
        if (abort_at == 0) check32({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit hit;
        rstn            = 1'b0;
        cfg_start       = 1'b0;
        cfg_abort       = 1'b0;
        cfg_base_addr   = 32'd0;
        cfg_total_bytes = 32'd0;
        cfg_burst_beats = 5'd0;
        cfg_loops       = 16'd0;
        repeat (3) @(negedge clk);

        // Reset state.
        check32("rst_rd_start", 32'(rd_start), 32'd0);
        check32("rst_rd_addr", rd_addr, 32'd0);
        check32("rst_rd_len", rd_len, 32'd0);
        check32("rst_busy", 32'(sts_busy), 32'd0);
        check32("rst_done", 32'(sts_done), 32'd0);
        check32("rst_timeout", 32'(sts_timeout), 32'd0);
        check32("rst_cycles", sts_cycles, 32'd0);
        check32("rst_bursts", sts_bursts, 32'd0);
        check32("rst_bytes", sts_bytes, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        run("basic",      32'h0000_1000, 32'd256,  5'd16, 16'd1, 0, 1'b0, 0);
        run("cross4k",    32'h0000_1FC0, 32'd512,  5'd16, 16'd1, 0, 1'b1, 0);
        run("loops",      32'h0000_0000, 32'd40,   5'd0,  16'd3, 0, 1'b0, 0);
        run("abort",      32'h0000_0000, 32'd4096, 5'd16, 16'd1, 3, 1'b0, 0);
        run("abort_last", 32'h0000_2000, 32'd128,  5'd16, 16'd1, 1, 1'b0, 0);
        run("zero_len",   32'h0000_0100, 32'd7,    5'd16, 16'd1, 0, 1'b0, 0);
        run("clamp",      32'h1234_5673, 32'h10F,  5'd31, 16'd0, 0, 1'b0, 0);
        run("busy_mstr",  32'h0000_0000, 32'd64,   5'd16, 16'd1, 0, 1'b0, 10);

        // Master that never returns to idle.
        cfg_base_addr   = 32'h0000_3000;
        cfg_total_bytes = 32'd128;
        cfg_burst_beats = 5'd16;
        cfg_loops       = 16'd1;
        m_stuck         = 1'b1;
        begin
            int n;
            logic [31:0] eb;
            push_bursts(32'h0000_3000, 32'd128, 5'd16, 16'd1, 32'h7FFF_FFFF, n, eb);
        end
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
`ifdef DDR_RD_BW_SCHED_TIMEOUT_EN
        hit = 1'b0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (sts_done) begin
                hit = 1'b1;
                break;
            end
        end
        check32("wd_done", 32'(hit), 32'd1);
        check32("wd_timeout", 32'(sts_timeout), 32'd1);
        check32("wd_busy", 32'(sts_busy), 32'd0);
        check32("wd_rd_start", 32'(rd_start), 32'd0);
        check32("wd_bursts", sts_bursts, 32'd0);
        check32("wd_bytes", sts_bytes, 32'd0);
`else
        hit = 1'b0;
        repeat (300) @(negedge clk);
        check32("stuck_busy", 32'(sts_busy), 32'd1);
        check32("stuck_done", 32'(sts_done), 32'd0);
        check32("stuck_timeout", 32'(sts_timeout), 32'd0);
        check32("stuck_rd_start", 32'(rd_start), 32'd0);
`endif
        m_stuck = 1'b0;
        rstn    = 1'b0;
        @(negedge clk);
        rstn    = 1'b1;
        exp_q.delete();
        @(negedge clk);

        // Reset while the second burst is outstanding.
        cfg_base_addr   = 32'h0000_1000;
        cfg_total_bytes = 32'd256;
        cfg_burst_beats = 5'd16;
        cfg_loops       = 16'd1;
        accepts         = 0;
        begin
            int n;
            logic [31:0] eb;
            push_bursts(32'h0000_1000, 32'd256, 5'd16, 16'd1, 32'h7FFF_FFFF, n, eb);
        end
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (accepts >= 2) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check32("mid_second_burst", 32'(hit), 32'd1);
        @(negedge clk);
        check32("mid_bursts", sts_bursts, 32'd1);
        check32("mid_bytes", sts_bytes, 32'd128);
        rstn = 1'b0;
        @(negedge clk);
        check32("mrst_rd_start", 32'(rd_start), 32'd0);
        check32("mrst_busy", 32'(sts_busy), 32'd0);
        check32("mrst_done", 32'(sts_done), 32'd0);
        check32("mrst_cycles", sts_cycles, 32'd0);
        check32("mrst_bursts", sts_bursts, 32'd0);
        check32("mrst_bytes", sts_bytes, 32'd0);
        rstn = 1'b1;
        exp_q.delete();
        @(negedge clk);

        run("after_rst", 32'h0000_1000, 32'd256, 5'd16, 16'd1, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
